// File: rtl/psram_qspi_ctrl.sv
// QPI-mode PSRAM controller: req/ack front end, MSB-first command/address/data shifting, per-window access budget.
// Optional feature macro: PSRAM_ROMPROT_EN drops writes aimed at the lower 16 KB ROM image.
module psram_qspi_ctrl #(
   parameter int         ADDR_W    = 24,
   parameter int         BURST     = 1,
   parameter int         RD_WAIT   = 6,
   parameter int         ACC_LIMIT = 112,
   parameter logic [7:0] CMD_RD    = 8'hEB,
   parameter logic [7:0] CMD_WR    = 8'h38
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [8*BURST-1:0]   wdata,
   output logic [8*BURST-1:0]   rdata,
   output logic                 ack,
   output logic                 busy,
   input  logic                 win_start,
   output logic                 sck_en,
   output logic                 cs_n,
   output logic [3:0]           qio_o,
   output logic                 qio_oe,
   input  logic [3:0]           qio_i
);

   localparam int DW  = 8 * BURST;
   localparam int SRW = 32 + DW;
   localparam int BW  = (ACC_LIMIT < 2) ? 1 : $clog2(ACC_LIMIT + 1);
   localparam logic [BW-1:0] LIMIT      = BW'(ACC_LIMIT);
   localparam logic [23:0]   ALIGN_MASK = ~24'(BURST - 1);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WAIT,
      DATA,
      DROP,
      DONE
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [7:0]      cnt_q;
   logic [7:0]      cnt_d;
   logic            we_q;
   logic [SRW-1:0]  sr_q;
   logic [DW-1:0]   rd_sr_q;
   logic [DW-1:0]   rd_next;
   logic [DW-1:0]   rd_bytes;
   logic [DW-1:0]   wdata_ord;
   logic [BW-1:0]   budget_q;
   logic [23:0]     bus_addr;
   logic            budget_ok;
   logic            start;
   logic            rom_drop;

   assign bus_addr  = 24'(addr) & ALIGN_MASK;
   assign budget_ok = (ACC_LIMIT == 0) || (budget_q < LIMIT);
   assign rd_next   = {rd_sr_q[DW-5:0], qio_i};

`ifdef PSRAM_ROMPROT_EN
   assign rom_drop = we && (bus_addr[23:14] == 10'd0);
`else
   assign rom_drop = 1'b0;
`endif

   // Byte 0 travels first on the bus, so it sits at the top of the shift stream.
   always_comb begin
      wdata_ord = '0;
      rd_bytes  = '0;
      for (int i = 0; i < BURST; i++) begin
         wdata_ord[8*(BURST-1-i) +: 8] = wdata[8*i +: 8];
         rd_bytes[8*i +: 8]            = rd_next[8*(BURST-1-i) +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      cs_n    = 1'b1;
      sck_en  = 1'b0;
      qio_oe  = 1'b0;
      ack     = 1'b0;
      busy    = (state_q != IDLE);
      if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
      case (state_q)
         IDLE: begin
            if (req && budget_ok && !win_start) begin
               start = 1'b1;
               if (rom_drop) begin
                  state_d = DROP;
               end else begin
                  state_d = CMD;
                  cnt_d   = 8'd1;
               end
            end
         end
         CMD: begin
            cs_n   = 1'b0;
            sck_en = 1'b1;
            qio_oe = 1'b1;
            if (cnt_q == 8'd0) begin
               state_d = ADDR;
               cnt_d   = 8'd5;
            end
         end
         ADDR: begin
            cs_n   = 1'b0;
            sck_en = 1'b1;
            qio_oe = 1'b1;
            if (cnt_q == 8'd0) begin
               if (!we_q && (RD_WAIT != 0)) begin
                  state_d = WAIT;
                  cnt_d   = 8'(RD_WAIT - 1);
               end else begin
                  state_d = DATA;
                  cnt_d   = 8'(2 * BURST - 1);
               end
            end
         end
         WAIT: begin
            cs_n   = 1'b0;
            sck_en = 1'b1;
            if (cnt_q == 8'd0) begin
               state_d = DATA;
               cnt_d   = 8'(2 * BURST - 1);
            end
         end
         DATA: begin
            cs_n   = 1'b0;
            sck_en = 1'b1;
            qio_oe = we_q;
            if (cnt_q == 8'd0) begin
               state_d = DONE;
            end
         end
         // A protected write idles one cycle with cs_n high so ack keeps a fixed two-cycle latency.
         DROP: begin
            state_d = DONE;
         end
         DONE: begin
            ack     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign qio_o = qio_oe ? sr_q[SRW-1 -: 4] : 4'h0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_q    <= 1'b0;
         sr_q    <= '0;
         rd_sr_q <= '0;
         rdata   <= '0;
      end else begin
         if (start) begin
            we_q <= we;
            sr_q <= {(we ? CMD_WR : CMD_RD), bus_addr, wdata_ord};
         end else if (qio_oe) begin
            sr_q <= {sr_q[SRW-5:0], 4'h0};
         end
         if ((state_q == DATA) && !we_q) begin
            rd_sr_q <= rd_next;
            if (cnt_q == 8'd0) begin
               rdata <= rd_bytes;
            end
         end
      end
   end

   // win_start wins over a same-cycle start; the start itself is blocked in IDLE that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         budget_q <= '0;
      end else if (win_start) begin
         budget_q <= '0;
      end else if (start && !rom_drop && (ACC_LIMIT != 0) && (budget_q != LIMIT)) begin
         budget_q <= budget_q + BW'(1);
      end
   end

endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Directed bench for psram_qspi_ctrl: a BURST=1/ACC_LIMIT=3 instance with a small PSRAM model and a BURST=4 unlimited instance.
module tb_psram_qspi_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        win_start = 1'b0;
   logic        win_start_b = 1'b0;

   logic        req_a = 1'b0;
   logic        we_a = 1'b0;
   logic [23:0] addr_a = '0;
   logic [7:0]  wdata_a = '0;
   logic [7:0]  rdata_a;
   logic        ack_a, busy_a, sck_en_a, cs_n_a, qio_oe_a;
   logic [3:0]  qio_o_a, qio_i_a;

   logic        req_b = 1'b0;
   logic        we_b = 1'b0;
   logic [23:0] addr_b = '0;
   logic [31:0] wdata_b = '0;
   logic [31:0] rdata_b;
   logic        ack_b, busy_b, sck_en_b, cs_n_b, qio_oe_b;
   logic [3:0]  qio_o_b, qio_i_b;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   psram_qspi_ctrl #(.ACC_LIMIT(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
      .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .win_start(win_start), .sck_en(sck_en_a),
      .cs_n(cs_n_a), .qio_o(qio_o_a), .qio_oe(qio_oe_a), .qio_i(qio_i_a)
   );

   psram_qspi_ctrl #(.BURST(4), .ACC_LIMIT(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
      .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .win_start(win_start_b), .sck_en(sck_en_b),
      .cs_n(cs_n_b), .qio_o(qio_o_b), .qio_oe(qio_oe_b), .qio_i(qio_i_b)
   );

   // PSRAM model A: 64 KB array, 6 dummy cycles, one byte per access.
   logic [7:0]  mem [0:65535];
   logic [3:0]  nib_a [0:31];
   int          mcnt_a = 0;
   logic [15:0] maddr_a;

   assign maddr_a = {nib_a[4], nib_a[5], nib_a[6], nib_a[7]};

   always_comb begin
      qio_i_a = 4'h0;
      if (mcnt_a == 14) qio_i_a = mem[maddr_a][7:4];
      else if (mcnt_a == 15) qio_i_a = mem[maddr_a][3:0];
   end

   always @(posedge clk) begin
      if (!cs_n_a) begin
         if (qio_oe_a && mcnt_a < 32) nib_a[mcnt_a] <= qio_o_a;
         mcnt_a <= mcnt_a + 1;
      end else begin
         if (mcnt_a == 10 && nib_a[0] == 4'h3 && nib_a[1] == 4'h8) mem[maddr_a] <= {nib_a[8], nib_a[9]};
         mcnt_a <= 0;
      end
   end

   // PSRAM model B: returns bytes 12,34,56,78 for any 4-byte read.
   logic [3:0] nib_b [0:31];
   int         mcnt_b = 0;

   always_comb begin
      qio_i_b = 4'h0;
      if (mcnt_b >= 14 && mcnt_b < 22) qio_i_b = 4'(mcnt_b - 13);
   end

   always @(posedge clk) begin
      if (!cs_n_b) begin
         if (qio_oe_b && mcnt_b < 32) nib_b[mcnt_b] <= qio_o_b;
         mcnt_b <= mcnt_b + 1;
      end else begin
         mcnt_b <= 0;
      end
   end

   task automatic do_access_a(input logic w, input logic [23:0] a, input logic [7:0] d,
                              output int lat, output int cslow, output logic oe8, output logic oe9,
                              output logic ack_after);
      @(posedge clk); #1;
      req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
      lat = 0; cslow = 0; oe8 = 1'b0; oe9 = 1'b0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!cs_n_a) cslow++;
         if (lat == 8) oe8 = qio_oe_a;
         if (lat == 9) oe9 = qio_oe_a;
      end while (!ack_a && lat < 60);
      req_a = 1'b0;
      @(posedge clk); #1;
      ack_after = ack_a;
   endtask

   task automatic do_access_b(input logic w, input logic [23:0] a, input logic [31:0] d,
                              output int lat, output int cslow);
      @(posedge clk); #1;
      req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
      lat = 0; cslow = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!cs_n_b) cslow++;
      end while (!ack_b && lat < 60);
      req_b = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (cs_n_a !== 1'b1) begin err_cnt++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs_n_a); end
      vec_cnt++; if (sck_en_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_sck_en: got %b expected 0", sck_en_a); end
      vec_cnt++; if (qio_oe_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_qio_oe: got %b expected 0", qio_oe_a); end
      vec_cnt++; if (qio_o_a !== 4'h0) begin err_cnt++; $display("[TB] FAIL reset_qio_o: got %h expected 0", qio_o_a); end
      vec_cnt++; if (ack_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_ack: got %b expected 0", ack_a); end
      vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
      vec_cnt++; if (rdata_a !== 8'h00) begin err_cnt++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata_a); end
      vec_cnt++; if (rdata_b !== 32'h0) begin err_cnt++; $display("[TB] FAIL reset_rdata_b: got %h expected 0", rdata_b); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++; if (cs_n_a !== 1'b1 || busy_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL post_reset_idle: got cs_n=%b busy=%b expected 1/0", cs_n_a, busy_a); end
   endtask

   task automatic test_read();
      logic [3:0] exp_n [0:7] = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
      int lat, cslow;
      logic oe8, oe9, ack_after;
      do_access_a(1'b0, 24'h004000, 8'h00, lat, cslow, oe8, oe9, ack_after);
      vec_cnt++; if (lat !== 17) begin err_cnt++; $display("[TB] FAIL read_latency: got %0d expected 17", lat); end
      vec_cnt++; if (cslow !== 16) begin err_cnt++; $display("[TB] FAIL read_cs_low: got %0d expected 16", cslow); end
      vec_cnt++; if (rdata_a !== 8'hA5) begin err_cnt++; $display("[TB] FAIL read_rdata: got %h expected A5", rdata_a); end
      for (int i = 0; i < 8; i++) begin
         vec_cnt++; if (nib_a[i] !== exp_n[i]) begin err_cnt++; $display("[TB] FAIL read_nibble%0d: got %h expected %h", i, nib_a[i], exp_n[i]); end
      end
      vec_cnt++; if (oe8 !== 1'b1 || oe9 !== 1'b0) begin err_cnt++; $display("[TB] FAIL read_oe_wait: got %b%b expected 10", oe8, oe9); end
      vec_cnt++; if (ack_after !== 1'b0) begin err_cnt++; $display("[TB] FAIL read_ack_pulse: got %b expected 0", ack_after); end
   endtask

   task automatic test_write();
      logic [3:0] exp_n [0:9] = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h3, 4'hC};
      int lat, cslow;
      logic oe8, oe9, ack_after;
      do_access_a(1'b1, 24'h008000, 8'h3C, lat, cslow, oe8, oe9, ack_after);
      vec_cnt++; if (lat !== 11) begin err_cnt++; $display("[TB] FAIL write_latency: got %0d expected 11", lat); end
      vec_cnt++; if (cslow !== 10) begin err_cnt++; $display("[TB] FAIL write_cs_low: got %0d expected 10", cslow); end
      for (int i = 0; i < 10; i++) begin
         vec_cnt++; if (nib_a[i] !== exp_n[i]) begin err_cnt++; $display("[TB] FAIL write_nibble%0d: got %h expected %h", i, nib_a[i], exp_n[i]); end
      end
      vec_cnt++; if (oe9 !== 1'b1) begin err_cnt++; $display("[TB] FAIL write_oe_data: got %b expected 1", oe9); end
      vec_cnt++; if (mem[16'h8000] !== 8'h3C) begin err_cnt++; $display("[TB] FAIL write_mem: got %h expected 3C", mem[16'h8000]); end
      vec_cnt++; if (rdata_a !== 8'hA5) begin err_cnt++; $display("[TB] FAIL write_keeps_rdata: got %h expected A5", rdata_a); end
   endtask

   // Four back-to-back reads against a limit of 3; the window pulse at cycle 81 overlaps the pending req.
   task automatic test_back_to_back_budget();
      int acks [0:7];
      int exp_acks [0:3] = '{17, 35, 53, 99};
      int nacks = 0;
      @(posedge clk); #1;
      win_start = 1'b1;
      @(posedge clk); #1;
      win_start = 1'b0;
      req_a = 1'b1; we_a = 1'b0; addr_a = 24'h004000;
      for (int cyc = 1; cyc <= 110; cyc++) begin
         @(posedge clk); #1;
         if (ack_a && nacks < 8) begin
            acks[nacks] = cyc;
            nacks++;
         end
         if (cyc == 99) req_a = 1'b0;
         if (cyc == 18) begin
            vec_cnt++; if (cs_n_a !== 1'b1 || busy_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL b2b_idle_gap: got cs_n=%b busy=%b expected 1/0", cs_n_a, busy_a); end
         end
         if (cyc == 19) begin
            vec_cnt++; if (busy_a !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_restart: got busy=%b expected 1", busy_a); end
         end
         if (cyc == 80) begin
            vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL budget_block: got busy=%b expected 0", busy_a); end
         end
         if (cyc == 81) win_start = 1'b1;
         if (cyc == 82) begin
            win_start = 1'b0;
            vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL win_defer: got busy=%b expected 0", busy_a); end
         end
         if (cyc == 83) begin
            vec_cnt++; if (cs_n_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL win_restart: got cs_n=%b expected 0", cs_n_a); end
         end
      end
      vec_cnt++; if (nacks !== 4) begin err_cnt++; $display("[TB] FAIL budget_ack_count: got %0d expected 4", nacks); end
      for (int i = 0; i < 4; i++) begin
         if (i < nacks) begin
            vec_cnt++; if (acks[i] !== exp_acks[i]) begin err_cnt++; $display("[TB] FAIL budget_ack%0d_cycle: got %0d expected %0d", i, acks[i], exp_acks[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, cslow;
      logic oe8, oe9, ack_after;
      logic saw_ack = 1'b0;
      @(posedge clk); #1;
      req_a = 1'b1; we_a = 1'b0; addr_a = 24'h004000;
      repeat (5) begin @(posedge clk); #1; end
      vec_cnt++; if (cs_n_a !== 1'b0 || sck_en_a !== 1'b1) begin err_cnt++; $display("[TB] FAIL mid_active: got cs_n=%b sck_en=%b expected 0/1", cs_n_a, sck_en_a); end
      reset_n = 1'b0;
      req_a = 1'b0;
      #1;
      vec_cnt++; if (cs_n_a !== 1'b1 || qio_oe_a !== 1'b0 || sck_en_a !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_reset_pins: got cs_n=%b oe=%b sck=%b expected 1/0/0", cs_n_a, qio_oe_a, sck_en_a); end
      repeat (5) begin
         @(posedge clk); #1;
         if (ack_a) saw_ack = 1'b1;
      end
      vec_cnt++; if (saw_ack !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_reset_noack: got %b expected 0", saw_ack); end
      reset_n = 1'b1;
      do_access_a(1'b0, 24'h004000, 8'h00, lat, cslow, oe8, oe9, ack_after);
      vec_cnt++; if (lat !== 17) begin err_cnt++; $display("[TB] FAIL after_reset_latency: got %0d expected 17", lat); end
      vec_cnt++; if (rdata_a !== 8'hA5) begin err_cnt++; $display("[TB] FAIL after_reset_rdata: got %h expected A5", rdata_a); end
   endtask

   task automatic test_burst();
      logic [3:0] exp_a [0:5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0};
      logic [3:0] exp_w [0:7] = '{4'h1, 4'hA, 4'h2, 4'hB, 4'h3, 4'hC, 4'h4, 4'hD};
      int lat, cslow;
      do_access_b(1'b0, 24'h123403, 32'h0, lat, cslow);
      vec_cnt++; if (lat !== 23) begin err_cnt++; $display("[TB] FAIL burst_read_latency: got %0d expected 23", lat); end
      vec_cnt++; if (cslow !== 22) begin err_cnt++; $display("[TB] FAIL burst_read_cs_low: got %0d expected 22", cslow); end
      for (int i = 0; i < 6; i++) begin
         vec_cnt++; if (nib_b[2+i] !== exp_a[i]) begin err_cnt++; $display("[TB] FAIL burst_addr_nibble%0d: got %h expected %h", i, nib_b[2+i], exp_a[i]); end
      end
      vec_cnt++; if (rdata_b !== 32'h78563412) begin err_cnt++; $display("[TB] FAIL burst_rdata: got %h expected 78563412", rdata_b); end
      do_access_b(1'b1, 24'h000010, 32'h4D3C2B1A, lat, cslow);
      vec_cnt++; if (lat !== 17) begin err_cnt++; $display("[TB] FAIL burst_write_latency: got %0d expected 17", lat); end
      for (int i = 0; i < 8; i++) begin
         vec_cnt++; if (nib_b[8+i] !== exp_w[i]) begin err_cnt++; $display("[TB] FAIL burst_wdata_nibble%0d: got %h expected %h", i, nib_b[8+i], exp_w[i]); end
      end
      vec_cnt++; if (rdata_b !== 32'h78563412) begin err_cnt++; $display("[TB] FAIL burst_write_keeps_rdata: got %h expected 78563412", rdata_b); end
   endtask

   task automatic test_rom_write();
      int lat, cslow;
      logic oe8, oe9, ack_after;
`ifdef PSRAM_ROMPROT_EN
      do_access_a(1'b1, 24'h001234, 8'h99, lat, cslow, oe8, oe9, ack_after);
      vec_cnt++; if (lat !== 2) begin err_cnt++; $display("[TB] FAIL rom_ack_latency: got %0d expected 2", lat); end
      vec_cnt++; if (cslow !== 0) begin err_cnt++; $display("[TB] FAIL rom_cs_low: got %0d expected 0", cslow); end
      vec_cnt++; if (mem[16'h1234] !== 8'h77) begin err_cnt++; $display("[TB] FAIL rom_mem: got %h expected 77", mem[16'h1234]); end
      for (int k = 0; k < 2; k++) begin
         do_access_a(1'b0, 24'h004000, 8'h00, lat, cslow, oe8, oe9, ack_after);
         vec_cnt++; if (lat !== 17) begin err_cnt++; $display("[TB] FAIL rom_budget_read%0d: got %0d expected 17", k, lat); end
      end
`else
      do_access_a(1'b1, 24'h001234, 8'h99, lat, cslow, oe8, oe9, ack_after);
      vec_cnt++; if (lat !== 11) begin err_cnt++; $display("[TB] FAIL low_write_latency: got %0d expected 11", lat); end
      vec_cnt++; if (mem[16'h1234] !== 8'h99) begin err_cnt++; $display("[TB] FAIL low_write_mem: got %h expected 99", mem[16'h1234]); end
`endif
   endtask

   initial begin
      mem[16'h4000] <= 8'hA5;
      mem[16'h8000] <= 8'h00;
      mem[16'h1234] <= 8'h77;
      test_reset();
      test_read();
      test_write();
      test_back_to_back_budget();
      test_reset_mid();
      test_burst();
      test_rom_write();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
